// File: rtl/shift_add_mul32.sv
// Sequential unsigned 32x32 -> 64 shift-and-add multiplier driving an external ripple-carry adder.
// Define SHIFT_ADD_MUL_OVF_EN to add the registered ovf output (product does not fit in 32 bits).
module shift_add_mul32 #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout
`ifdef SHIFT_ADD_MUL_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] ADD_WAIT = 3'd2;
  localparam logic [2:0] SHIFT    = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mc_q, mc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [63:0] product_q, product_d;
  logic        ovf_q, ovf_d;

  // The adder only ever sees the accumulator and multiplicand registers, so its
  // inputs move solely on LOAD/SHIFT edges and stay frozen while we wait for it.
  assign add_a   = hi_q;
  assign add_b   = mc_q;
  assign add_cin = 1'b0;
  assign busy    = (state_q == LOAD) || (state_q == ADD_WAIT) || (state_q == SHIFT);
  assign done    = (state_q == DONE);
  assign product = product_q;
`ifdef SHIFT_ADD_MUL_OVF_EN
  assign ovf     = ovf_q;
`endif

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    product_d = product_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mc_d    = mcand;
          lo_d    = mplier;
          hi_d    = 32'd0;
          cnt_d   = 6'd0;
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (lo_q[0]) begin
          wait_d  = SETTLE_RELOAD;
          state_d = ADD_WAIT;
        end else begin
          state_d = SHIFT;
        end
      end

      ADD_WAIT: begin
        if (wait_q == 8'd0) begin
          state_d = SHIFT;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end

      SHIFT: begin
        // The adder carry-out becomes bit 63, so the 33-bit partial sum is never truncated.
        if (lo_q[0]) begin
          {hi_d, lo_d} = {add_cout, add_sum, lo_q[31:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          // Capture on entry to DONE so product is already valid while done is high.
          product_d = {hi_d, lo_d};
          ovf_d     = (hi_d != 32'd0);
          state_d   = DONE;
        end else if (lo_q[1]) begin
          wait_d  = SETTLE_RELOAD;
          state_d = ADD_WAIT;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      mc_q      <= 32'd0;
      cnt_q     <= 6'd0;
      wait_q    <= 8'd0;
      product_q <= 64'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mc_q      <= mc_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
    end
  end

`ifndef SHIFT_ADD_MUL_OVF_EN
  // Without the overflow port the flag has no reader.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shift_add_mul32.sv
// Bench for shift_add_mul32: random and directed products against a plain a*b reference model.
// The adder is modelled as a delay line exactly SETTLE_CYCLES deep, so sampling too early is caught.
module tb_shift_add_mul32;

  localparam int unsigned SETTLE = 4;
  localparam int BUDGET = 33 + 32 * SETTLE + 20;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
`ifdef SHIFT_ADD_MUL_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int passes = 0;

  shift_add_mul32 #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
`ifdef SHIFT_ADD_MUL_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slow adder: the sum only reflects operands that have been stable for SETTLE edges.
  logic [32:0] adderPipe [SETTLE];
  always @(posedge clk) begin
    adderPipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    for (int i = 1; i < int'(SETTLE); i++) adderPipe[i] <= adderPipe[i-1];
  end
  assign {add_cout, add_sum} = adderPipe[SETTLE-1];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else passes++;
  endtask

  function automatic int expLatency(input logic [31:0] b);
    return 33 + int'(SETTLE) * $countones(b);
  endfunction

  task automatic checkOvf(input string tag, input logic [63:0] expProd);
`ifdef SHIFT_ADD_MUL_OVF_EN
    checkOutput({tag, " ovf"}, {63'd0, ovf}, {63'd0, expProd[63:32] != 32'd0});
`else
    if (expProd === 64'hx) $display("[TB] %s", tag);
`endif
  endtask

  // One full multiply; pokeAt >= 0 pulses start during that cycle of the operation.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int pokeAt, input string tag);
    logic [63:0] expProd;
    logic [63:0] heldProd;
    int n;
    int busyLow;
    int addaNonZero;
    int cinHigh;
    int extraDones;
    bit seen;
    expProd = 64'(a) * 64'(b);
    @(negedge clk);
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; seen = 0; busyLow = 0; addaNonZero = 0; cinHigh = 0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      start = (n == pokeAt);
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1;
      else if (!busy) busyLow++;
      if (add_a != 32'd0) addaNonZero++;
      if (add_cin) cinHigh++;
    end
    start = 1'b0;
    checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
    checkOutput({tag, " latency"}, 64'(n), 64'(expLatency(b)));
    checkOutput({tag, " product"}, product, expProd);
    checkOutput({tag, " busy low early"}, 64'(busyLow), 64'd0);
    checkOutput({tag, " busy in done"}, {63'd0, busy}, 64'd0);
    checkOutput({tag, " cin high"}, 64'(cinHigh), 64'd0);
    checkOvf(tag, expProd);
    if (b == 32'd0) checkOutput({tag, " add_a moved"}, 64'(addaNonZero), 64'd0);
    heldProd = product;
    @(posedge clk);
    #1 checkOutput({tag, " done width"}, {63'd0, done}, 64'd0);
    extraDones = 0;
    repeat ((pokeAt >= 0) ? BUDGET : 3) begin
      @(posedge clk);
      #1 if (done) extraDones++;
    end
    checkOutput({tag, " extra done"}, 64'(extraDones), 64'd0);
    checkOutput({tag, " product held"}, product, heldProd);
  endtask

  initial begin
    int n;
    bit seen;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    start = 1'b0;
    mcand = 32'd0;
    mplier = 32'd0;
    #1;
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset done", {63'd0, done}, 64'd0);
    checkOutput("reset product", product, 64'd0);
    checkOutput("reset add_a", {32'd0, add_a}, 64'd0);
    checkOutput("reset add_b", {32'd0, add_b}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    applyStimulus(32'd3, 32'd5, -1, "basic");
    applyStimulus(32'hDEADBEEF, 32'd0, -1, "zero");
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, -1, "max");
    applyStimulus(32'd7, 32'd9, 10, "busy start");

    @(negedge clk);
    mcand = 32'h10000;
    mplier = 32'h10000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 checkOutput("midop busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midop reset busy", {63'd0, busy}, 64'd0);
    checkOutput("midop reset done", {63'd0, done}, 64'd0);
    checkOutput("midop reset product", product, 64'd0);
    checkOutput("midop reset add_b", {32'd0, add_b}, 64'd0);
    @(negedge clk) reset = 1'b0;
    applyStimulus(32'd2, 32'd3, -1, "post reset");

    // Start held high across two operations.
    @(negedge clk);
    mcand = 32'd12;
    mplier = 32'd12;
    start = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < BUDGET) begin
      @(posedge clk);
      n++;
      #1 if (done) seen = 1;
    end
    checkOutput("b2b first latency", 64'(n), 64'(1 + expLatency(32'd12)));
    checkOutput("b2b first product", product, 64'd144);
    mcand = 32'h80000000;
    mplier = 32'd2;
    n = 0; seen = 0;
    while (!seen && n < BUDGET) begin
      @(posedge clk);
      n++;
      #1 if (done) seen = 1;
    end
    checkOutput("b2b second latency", 64'(n), 64'(2 + expLatency(32'd2)));
    checkOutput("b2b second product", product, 64'h100000000);
    checkOvf("b2b second", 64'h100000000);
    @(negedge clk) start = 1'b0;
    repeat (BUDGET) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : ($urandom & $urandom & $urandom);
      applyStimulus(ra, rb, -1, $sformatf("random%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
